// File: rtl/sha_round_ctrl_if.sv
// Handshake and control bundle between the SHA round controller and its datapath/message source.
// The slave side is the controller; the master side drives start/sizing/message-valid.
interface sha_round_ctrl_if;
    logic       start;
    logic       hash_size;
    logic       first_block;
    logic       msg_valid;
    logic       msg_ready;
    logic       busy;
    logic [6:0] cnt;
    logic       hash_size_q;
    logic       load_en;
    logic       load_iv;
    logic       round_en;
    logic       wsched_en;
    logic       final_en;
    logic       done;

    // msg_valid/msg_ready: a message-word pair is consumed in any cycle where both are high;
    // msg_ready is only raised in ROUND while cnt < 16, so msg_valid elsewhere is ignored.
    modport slave (
        input  start, hash_size, first_block, msg_valid,
        output msg_ready, busy, cnt, hash_size_q, load_en, load_iv,
               round_en, wsched_en, final_en, done
    );

    modport master (
        output start, hash_size, first_block, msg_valid,
        input  msg_ready, busy, cnt, hash_size_q, load_en, load_iv,
               round_en, wsched_en, final_en, done
    );
endinterface

// File: rtl/sha_round_ctrl.sv
// Round sequencer for a two-rounds-per-cycle SHA-256 / SHA-512 compression datapath.
// Walks IDLE -> LOAD -> ROUND (cnt 0..last step 2) -> FINAL -> DONE; state exposed on state_o.
module sha_round_ctrl (
    input  logic              clk,
    input  logic              resetn,
    sha_round_ctrl_if.slave   bus,
    output logic [2:0]        state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ROUND = 3'd2,
        S_FINAL = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [6:0] cnt_q, cnt_d;
    logic       hsize_q, hsize_d;
    logic       load_iv_q, load_iv_d;

    logic       round_en_w;
    logic       wsched_en_w;
    logic [6:0] last_w;

    assign last_w = hsize_q ? 7'd78 : 7'd62;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            cnt_q     <= 7'd0;
            hsize_q   <= 1'b0;
            load_iv_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hsize_q   <= hsize_d;
            load_iv_q <= load_iv_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hsize_d   = hsize_q;
        load_iv_d = load_iv_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d   = S_LOAD;
                    hsize_d   = bus.hash_size;
                    load_iv_d = bus.first_block;
                end
            end
            S_LOAD: begin
                cnt_d   = 7'd0;
                state_d = S_ROUND;
            end
            S_ROUND: begin
                // cnt parks at last so the ROMs keep a stable index through FINAL/DONE
                if (round_en_w) begin
                    if (cnt_q == last_w) state_d = S_FINAL;
                    else                 cnt_d   = cnt_q + 7'd2;
                end
            end
            S_FINAL: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wsched_en_w   = 1'b0;
        round_en_w    = 1'b0;
        bus.msg_ready = 1'b0;
        bus.load_en   = 1'b0;
        bus.final_en  = 1'b0;
        bus.done      = 1'b0;
        case (state_q)
            S_LOAD:  bus.load_en = 1'b1;
            S_ROUND: begin
                wsched_en_w   = (cnt_q >= 7'd16);
                round_en_w    = wsched_en_w | bus.msg_valid;
                bus.msg_ready = round_en_w & ~wsched_en_w;
            end
            S_FINAL: bus.final_en = 1'b1;
            S_DONE:  bus.done     = 1'b1;
            default: ;
        endcase
    end

    assign bus.busy        = (state_q != S_IDLE);
    assign bus.cnt         = cnt_q;
    assign bus.hash_size_q = hsize_q;
    assign bus.load_iv     = load_iv_q;
    assign bus.round_en    = round_en_w;
    assign bus.wsched_en   = wsched_en_w;
    assign state_o         = state_q;

endmodule

// File: tb/tb_sha_round_ctrl.sv
// Directed bench for sha_round_ctrl: every cycle of each block is compared against a
// hand-derived output vector {busy,load_en,load_iv,hash_size_q,round_en,msg_ready,wsched_en,final_en,done,cnt}.
module tb_sha_round_ctrl;

    logic       clk;
    logic       resetn;
    logic [2:0] state_dbg;
    int         checks;
    int         errors;
    int         cnt_m;
    logic       hsq_m;
    logic       liv_m;

    sha_round_ctrl_if bus ();

    sha_round_ctrl dut (
        .clk     (clk),
        .resetn  (resetn),
        .bus     (bus),
        .state_o (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] vec(input logic busy, input logic load_en, input logic load_iv,
                                        input logic hsq, input logic round_en, input logic msg_ready,
                                        input logic wsched, input logic final_en, input logic done,
                                        input int c);
        logic [6:0] c7;
        c7 = c[6:0];
        return {busy, load_en, load_iv, hsq, round_en, msg_ready, wsched, final_en, done, c7};
    endfunction

    task automatic chk(input string tag, input logic [15:0] exp);
        logic [15:0] obs;
        obs = {bus.busy, bus.load_en, bus.load_iv, bus.hash_size_q, bus.round_en, bus.msg_ready,
               bus.wsched_en, bus.final_en, bus.done, bus.cnt};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0t observed=%h expected=%h", tag, $time, obs, exp);
        end
    endtask

    // Entered in an IDLE cycle (after the edge); returns in the IDLE cycle that follows DONE.
    // start_mode: 0 = single start pulse, 1 = extra pulses at T+5 and in DONE, 2 = start held high.
    task automatic do_block(input logic hs, input logic fb, input int stall_at, input int stall_len,
                            input int start_mode, input logic toggle);
        int last;
        last = hs ? 78 : 62;
        bus.start       = 1'b1;
        bus.hash_size   = hs;
        bus.first_block = fb;
        bus.msg_valid   = 1'b1;
        step();
        if (start_mode != 2) bus.start = 1'b0;
        if (toggle) begin
            bus.hash_size   = ~hs;
            bus.first_block = ~fb;
        end
        #1;
        chk("load", vec(1, 1, fb, hs, 0, 0, 0, 0, 0, cnt_m));
        hsq_m = hs;
        liv_m = fb;
        cnt_m = 0;
        step();
        for (int c = 0; c <= last; c += 2) begin
            if (c == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    bus.msg_valid = 1'b0;
                    #1;
                    chk("stall", vec(1, 0, liv_m, hsq_m, 0, 0, 0, 0, 0, c));
                    step();
                end
            end
            bus.msg_valid = !(stall_len > 0 && c == 20);
            if (start_mode == 1 && c == 6) bus.start = 1'b1;
            else if (start_mode != 2)      bus.start = 1'b0;
            #1;
            chk("round", vec(1, 0, liv_m, hsq_m, 1, (c < 16), (c >= 16), 0, 0, c));
            step();
        end
        bus.msg_valid = 1'b1;
        if (start_mode != 2) bus.start = 1'b0;
        cnt_m = last;
        #1;
        chk("final", vec(1, 0, liv_m, hsq_m, 0, 0, 0, 1, 0, cnt_m));
        step();
        if (start_mode == 1) bus.start = 1'b1;
        #1;
        chk("done", vec(1, 0, liv_m, hsq_m, 0, 0, 0, 0, 1, cnt_m));
        step();
        chk("idle", vec(0, 0, liv_m, hsq_m, 0, 0, 0, 0, 0, cnt_m));
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        cnt_m           = 0;
        hsq_m           = 1'b0;
        liv_m           = 1'b0;
        resetn          = 1'b0;
        bus.start       = 1'b0;
        bus.hash_size   = 1'b0;
        bus.first_block = 1'b0;
        bus.msg_valid   = 1'b0;
        repeat (3) step();
        resetn = 1'b1;
        chk("reset", vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // SHA-256 from IV, no stalls: 36 cycles start to IDLE
        do_block(1'b0, 1'b1, -1, 0, 0, 1'b0);
        // SHA-512 chained from previous digest
        do_block(1'b1, 1'b0, -1, 0, 0, 1'b0);
        // 3-cycle stall at cnt=4, msg_valid dropped once at cnt=20 must not stall
        do_block(1'b0, 1'b1, 4, 3, 0, 1'b0);
        // spurious start pulses mid-block and during DONE are ignored
        do_block(1'b0, 1'b1, -1, 0, 1, 1'b0);
        bus.start = 1'b0;
        step();
        chk("idle_after_spurious", vec(0, 0, liv_m, hsq_m, 0, 0, 0, 0, 0, cnt_m));

        // back-to-back with start held; hash_size/first_block toggled after acceptance
        do_block(1'b1, 1'b1, -1, 0, 2, 1'b1);
        do_block(1'b0, 1'b0, -1, 0, 0, 1'b0);

        // abort at T+20 with a start on the reset edge
        bus.start       = 1'b1;
        bus.hash_size   = 1'b0;
        bus.first_block = 1'b1;
        bus.msg_valid   = 1'b1;
        step();
        bus.start = 1'b0;
        hsq_m     = 1'b0;
        liv_m     = 1'b1;
        repeat (19) step();
        chk("pre_reset", vec(1, 0, 1, 0, 1, 0, 1, 0, 0, 36));
        resetn    = 1'b0;
        bus.start = 1'b1;
        step();
        resetn    = 1'b1;
        bus.start = 1'b0;
        #1;
        chk("abort_reset", vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cnt_m = 0;
        hsq_m = 1'b0;
        liv_m = 1'b0;
        step();
        do_block(1'b0, 1'b1, -1, 0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
